subleq_ctrl: RTL

SUBLEQ_CTRL -- requirements
Module: subleq_ctrl

---
 rtl/subleq_pkg.sv | 28 ++
 rtl/subleq_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/subleq_pkg.sv
// Shared types and widths for the SUBLEQ sequencer.
// Holds the state encoding, the bus widths and the branch test.
// No logic of its own; imported by subleq_ctrl.
package subleq_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // One state per clock; FA..WE together form one instruction.
  typedef enum logic [3:0] {
    S_IDLE,
    S_FA,
    S_FB,
    S_FC,
    S_RA,
    S_RB,
    S_WS,
    S_WP,
    S_WE,
    S_HALT
  } state_t;

  // SUBLEQ branch condition: result is negative or zero.
  function automatic logic is_leq(input logic [DATA_W-1:0] res);
    return res[DATA_W-1] | (res == '0);
  endfunction

endpackage

// File: rtl/subleq_ctrl.sv
// SUBLEQ instruction sequencer driving an asynchronous-style SRAM.
// Latency: 8 clocks per instruction (FA..WE), plus 1 IDLE clock at run start.
// Backpressure: none; run=0 only takes effect at the next instruction boundary.
module subleq_ctrl
  import subleq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_PC = 8'h00,
  parameter logic [ADDR_W-1:0] HALT_PC  = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              ram_ope_n,
  output logic              ram_ctl,
  output logic              ram_ena_n,
  output logic [ADDR_W-1:0] ram_adr,
  input  logic [DATA_W-1:0] ram_dat_i,
  output logic [DATA_W-1:0] ram_dat_o,
  output logic              ram_dat_oe,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              instr_done
);

  state_t r_state;
  state_t w_state_nxt;

  // Instruction operands: A, B, C fetched words and mem[A].
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_a;
  logic [ADDR_W-1:0] r_b;
  logic [ADDR_W-1:0] r_c;
  logic [DATA_W-1:0] r_ma;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_new;
  logic [DATA_W-1:0] w_res;
  logic              w_leq;

  // Output flops and the values they load at the next edge.
  logic              r_ope_n, r_ctl, r_ena_n, r_oe, r_busy, r_halted, r_done;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat_o;
  logic              w_ope_n, w_ctl, w_ena_n, w_oe, w_busy, w_halted, w_done;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_dat_o;

  // mem[B] is not kept: it goes straight into the difference as RB exits,
  // and the result then lives in the write-data flop until WE.
  assign w_res    = ram_dat_i - r_ma;
  assign w_leq    = is_leq(r_dat_o);
  assign w_pc_new = w_leq ? r_c : r_pc + 8'd3;

  // Next PC: load START_PC when leaving IDLE, commit the branch result at WE.
  always_comb begin
    w_pc_nxt = r_pc;
    if (r_state == S_IDLE && run) begin
      w_pc_nxt = START_PC;
    end else if (r_state == S_WE) begin
      w_pc_nxt = w_pc_new;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; run is only sampled in IDLE, WE and HALT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (run) w_state_nxt = S_FA;
      S_FA:    w_state_nxt = S_FB;
      S_FB:    w_state_nxt = S_FC;
      S_FC:    w_state_nxt = S_RA;
      S_RA:    w_state_nxt = S_RB;
      S_RB:    w_state_nxt = S_WS;
      S_WS:    w_state_nxt = S_WP;
      S_WP:    w_state_nxt = S_WE;
      S_WE: begin
        if (w_pc_new == HALT_PC) w_state_nxt = S_HALT;
        else if (run)            w_state_nxt = S_FA;
        else                     w_state_nxt = S_IDLE;
      end
      S_HALT:  if (!run) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the state being entered, so every pin comes off a flop
  // and is valid for the whole of its state.
  always_comb begin
    w_ena_n  = 1'b1;
    w_ope_n  = 1'b1;
    w_ctl    = 1'b1;
    w_oe     = 1'b0;
    w_adr    = r_adr;
    w_dat_o  = r_dat_o;
    w_busy   = 1'b0;
    w_halted = 1'b0;
    w_done   = 1'b0;
    case (w_state_nxt)
      S_FA: begin
        w_ena_n = 1'b0; w_ope_n = 1'b0; w_busy = 1'b1;
        w_adr   = w_pc_nxt;
      end
      S_FB: begin
        w_ena_n = 1'b0; w_ope_n = 1'b0; w_busy = 1'b1;
        w_adr   = r_pc + 8'd1;
      end
      S_FC: begin
        w_ena_n = 1'b0; w_ope_n = 1'b0; w_busy = 1'b1;
        w_adr   = r_pc + 8'd2;
      end
      S_RA: begin
        w_ena_n = 1'b0; w_ope_n = 1'b0; w_busy = 1'b1;
        w_adr   = r_a;
      end
      S_RB: begin
        w_ena_n = 1'b0; w_ope_n = 1'b0; w_busy = 1'b1;
        w_adr   = r_b;
      end
      S_WS: begin
        w_ena_n = 1'b0; w_oe = 1'b1; w_busy = 1'b1;
        w_adr   = r_b;
        w_dat_o = w_res;
      end
      // Only ctl changes in WP and WE: the RAM strobes on ctl falling
      // while address and data are already settled.
      S_WP: begin
        w_ena_n = 1'b0; w_oe = 1'b1; w_ctl = 1'b0; w_busy = 1'b1;
      end
      S_WE: begin
        w_ena_n = 1'b0; w_oe = 1'b1; w_busy = 1'b1; w_done = 1'b1;
      end
      S_HALT:  w_halted = 1'b1;
      default: ;
    endcase
  end

  // Output flops; async reset returns ctl high without a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ena_n  <= 1'b1;
      r_ope_n  <= 1'b1;
      r_ctl    <= 1'b1;
      r_oe     <= 1'b0;
      r_adr    <= '0;
      r_dat_o  <= '0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_ena_n  <= w_ena_n;
      r_ope_n  <= w_ope_n;
      r_ctl    <= w_ctl;
      r_oe     <= w_oe;
      r_adr    <= w_adr;
      r_dat_o  <= w_dat_o;
      r_busy   <= w_busy;
      r_halted <= w_halted;
      r_done   <= w_done;
    end
  end

  // Datapath: PC and operand latches, each captured on the edge leaving its read state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= START_PC;
      r_a  <= '0;
      r_b  <= '0;
      r_c  <= '0;
      r_ma <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (r_state == S_FA) r_a  <= ram_dat_i;
      if (r_state == S_FB) r_b  <= ram_dat_i;
      if (r_state == S_FC) r_c  <= ram_dat_i;
      if (r_state == S_RA) r_ma <= ram_dat_i;
    end
  end

  assign ram_ena_n  = r_ena_n;
  assign ram_ope_n  = r_ope_n;
  assign ram_ctl    = r_ctl;
  assign ram_dat_oe = r_oe;
  assign ram_adr    = r_adr;
  assign ram_dat_o  = r_dat_o;
  assign pc         = r_pc;
  assign busy       = r_busy;
  assign halted     = r_halted;
  assign instr_done = r_done;

endmodule
